ksa: RTL and testbench

ARC4 key-scheduling engine: the reader/permuter that consumes the 256-byte S memory once the init stage has written S[i] = i. On a start handshake it runs the 256-iteration key-scheduling loop. Each iteration reads S[i] and S[j], updates j with the secret key, and writes the swapped pair back through the same single-port S RAM interface the init stage uses. It sits between init and the PRGA/decrypt stage and is sequenced by the top-level controller via en/rdy.

---
 rtl/ksa.sv | 113 +++++++++++
 tb/tb_ksa.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ksa.sv
// ARC4 key-scheduling engine: permutes the 256-byte S memory in place using a
// 24-bit key, one read-read-write-write iteration per index i.
module ksa (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  addr,
  input  logic [7:0]  rddata,
  output logic [7:0]  wrdata,
  output logic        wren,
  output logic [2:0]  state_dbg
);

  // Handshake: a run starts on a rising edge where en=1 and rdy=1; rdy then
  // stays low until the 256th iteration has written back, and en is ignored.
  typedef enum logic [2:0] {
    IDLE, RD_I, LATCH_I, RD_J, LATCH_J, WR_I, WR_J
  } state_t;

  state_t      state;
  logic [7:0]  i;
  logic [7:0]  j;
  logic [1:0]  kidx;
  logic [7:0]  si;
  logic [23:0] k;
  logic [7:0]  k_byte;
  logic [7:0]  j_next;

  always_comb begin
    k_byte = k[23:16];
    case (kidx)
      2'd1:    k_byte = k[15:8];
      2'd2:    k_byte = k[7:0];
      default: k_byte = k[23:16];
    endcase
  end

  assign j_next    = j + rddata + k_byte;
  assign state_dbg = state;

  // wrdata doubles as the sj capture: it is loaded in LATCH_J and driven in WR_I.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      i      <= 8'd0;
      j      <= 8'd0;
      kidx   <= 2'd0;
      si     <= 8'd0;
      k      <= 24'd0;
      rdy    <= 1'b1;
      wren   <= 1'b0;
      addr   <= 8'd0;
      wrdata <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            k     <= key;
            i     <= 8'd0;
            j     <= 8'd0;
            kidx  <= 2'd0;
            addr  <= 8'd0;
            rdy   <= 1'b0;
            wren  <= 1'b0;
            state <= RD_I;
          end
        end
        RD_I: begin
          addr  <= i;
          state <= LATCH_I;
        end
        LATCH_I: begin
          si    <= rddata;
          j     <= j_next;
          addr  <= j_next;
          state <= RD_J;
        end
        RD_J: begin
          addr  <= j;
          state <= LATCH_J;
        end
        LATCH_J: begin
          addr   <= i;
          wrdata <= rddata;
          wren   <= 1'b1;
          state  <= WR_I;
        end
        WR_I: begin
          addr   <= j;
          wrdata <= si;
          state  <= WR_J;
        end
        WR_J: begin
          i    <= i + 8'd1;
          kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
          wren <= 1'b0;
          if (i == 8'hFF) begin
            addr  <= 8'd0;
            rdy   <= 1'b1;
            state <= IDLE;
          end else begin
            addr  <= i + 8'd1;
            state <= RD_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa: registered-read RAM model, plain-arithmetic ARC4
// key-schedule reference, write-trace scoreboard and final S comparison.
module tb_ksa;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] key;
  logic        rdy;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;
  logic [2:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  ksa dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .addr      (addr),
    .rddata    (rddata),
    .wrdata    (wrdata),
    .wren      (wren),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // RAM model with 1-cycle registered read
  logic [7:0] mem [256];
  logic [7:0] load_img [256];
  logic       load_en;
  logic [7:0] ram_q;
  bit         poison_on;
  int         phase;
  logic [7:0] garbage;

  always @(posedge clk) begin
    if (load_en) mem <= load_img;
    else if (wren) mem[addr] <= wrdata;
    ram_q <= mem[addr];
  end

  // In RD_I / RD_J cycles (phases 0 and 2 of each iteration) feed junk data
  assign rddata = (poison_on && ((phase % 6) == 0 || (phase % 6) == 2)) ? garbage : ram_q;

  // Write monitor
  logic [15:0] wr_log [$];
  int idle_wr = 0;

  always @(negedge clk) begin
    if (!rst && wren) begin
      wr_log.push_back({addr, wrdata});
      if (rdy) idle_wr++;
    end
  end

  // Scoreboard / reference model
  logic [15:0] exp_q [$];
  logic [7:0]  model_s [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_s(input bit shuffle);
    logic [7:0] t;
    int r;
    for (int a = 0; a < 256; a++) model_s[a] = 8'(a);
    if (shuffle) begin
      for (int a = 255; a > 0; a--) begin
        r = $urandom_range(0, a);
        t = model_s[a];
        model_s[a] = model_s[r];
        model_s[r] = t;
      end
    end
    for (int a = 0; a < 256; a++) load_img[a] = model_s[a];
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // ARC4 KSA: j += S[i] + key[i mod 3]; swap S[i], S[j]
  task automatic model_ksa(input logic [23:0] kk);
    int jj;
    logic [7:0] kb;
    logic [7:0] t;
    exp_q.delete();
    jj = 0;
    for (int ii = 0; ii < 256; ii++) begin
      kb = 8'((kk >> (8 * (2 - (ii % 3)))) & 24'hFF);
      jj = (jj + int'(model_s[ii]) + int'(kb)) % 256;
      exp_q.push_back({8'(ii), model_s[jj]});
      exp_q.push_back({8'(jj), model_s[ii]});
      t = model_s[ii];
      model_s[ii] = model_s[jj];
      model_s[jj] = t;
    end
  endtask

  task automatic run(input logic [23:0] kk, input bit hold_en, input bit chg_key,
                     input bit psn, output int base);
    int n;
    int mism;
    logic [15:0] e;
    model_ksa(kk);
    @(negedge clk);
    check("pre_rdy", rdy, 1);
    base = wr_log.size();
    key = kk;
    en = 1'b1;
    poison_on = psn;
    @(posedge clk);
    #1;
    phase = 0;
    garbage = 8'($urandom_range(0, 255));
    check("accept_rdy_low", rdy, 0);
    if (!hold_en) en = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      phase = n;
      garbage = 8'($urandom_range(0, 255));
      if (chg_key && n == 700) key = 24'hFFFFFF;
      if (rdy) break;
    end
    poison_on = 1'b0;
    check("latency", n, 1536);
    check("wren_cycles", wr_log.size() - base, 512);
    for (int w = 0; w < 512; w++) begin
      e = exp_q.pop_front();
      if (base + w < wr_log.size()) check("write", wr_log[base + w], e);
      else check("write_missing", w, 512);
    end
    mism = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== model_s[a]) mism++;
    check("final_s", mism, 0);
  endtask

  initial begin
    int b;
    int cnt;
    rst = 1'b1;
    en = 1'b0;
    key = 24'd0;
    load_en = 1'b0;
    poison_on = 1'b0;
    phase = 0;
    garbage = 8'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", rdy, 1);
    check("rst_wren", wren, 0);
    check("rst_addr", addr, 8'h00);
    check("rst_wrdata", wrdata, 8'h00);
    check("rst_state", state_dbg, 3'd0);
    @(negedge clk);
    rst = 1'b0;

    // Identity S, zero key: explicit first-iteration trace
    load_s(1'b0);
    run(24'h000000, 1'b0, 1'b0, 1'b0, b);
    check("k0_it0_a", wr_log[b + 0], 16'h0000);
    check("k0_it0_b", wr_log[b + 1], 16'h0000);
    check("k0_it1_a", wr_log[b + 2], 16'h0101);
    check("k0_it1_b", wr_log[b + 3], 16'h0101);
    check("k0_it2_a", wr_log[b + 4], 16'h0203);
    check("k0_it2_b", wr_log[b + 5], 16'h0302);

    // Key byte order: byte0 is key[23:16]
    load_s(1'b0);
    run(24'h010000, 1'b0, 1'b0, 1'b0, b);
    check("kb0_it0_a", wr_log[b + 0], 16'h0001);
    check("kb0_it0_b", wr_log[b + 1], 16'h0100);

    // j wrap with junk on rddata outside the latch cycles
    load_s(1'b0);
    run(24'h00033C, 1'b0, 1'b0, 1'b1, b);

    // Random keys over shuffled S
    for (int t = 0; t < 3; t++) begin
      load_s(1'b1);
      run(24'($urandom()), 1'b0, 1'b0, t[0], b);
    end

    // en held high and key changed mid-run; then reset during the rerun
    load_s(1'b0);
    run(24'h5A17C3, 1'b1, 1'b1, 1'b0, b);
    @(posedge clk);
    #1;
    check("rerun_accept", rdy, 0);
    en = 1'b0;
    cnt = 0;
    while (!wren && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("rerun_reach_wr", wren, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rdy", rdy, 1);
    check("midrst_wren", wren, 0);
    check("midrst_addr", addr, 8'h00);
    @(posedge clk);
    #1;
    check("midrst2_rdy", rdy, 1);
    check("midrst2_wren", wren, 0);
    rst = 1'b0;

    // Restart after reset must begin from i=0, j=0
    load_s(1'b0);
    run(24'h000000, 1'b0, 1'b0, 1'b0, b);
    check("post_rst_it2_a", wr_log[b + 4], 16'h0203);
    check("post_rst_it2_b", wr_log[b + 5], 16'h0302);

    check("wren_in_idle", idle_wr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
